// File: rtl/universal_down_counter.sv
// ---------------------------------------------------------------------------
// UniversalDownCounter
//
// Loadable binary down-counter / timer with a one-cycle terminal-count pulse.
// The host loads a start value and starts the count. The count then
// decrements by one on every cycle with en=1 until it reaches zero.
//   - In one-shot mode (mode=0) the counter then parks in DONE.
//   - In auto-reload mode (mode=1) it reloads and keeps running.
//
// Ports
//   clk       in   1      system clock, all state on rising edge
//   rst       in   1      asynchronous reset, active-low
//   load      in   1      capture load_val into count and reload register
//   load_val  in   WIDTH  start / reload value
//   start     in   1      begin counting (IDLE) / restart (DONE)
//   stop      in   1      abort to IDLE, count keeps its value
//   pause     in   1      level, freezes the count while high (RUN<->HOLD)
//   en        in   1      count tick, one decrement per enabled cycle
//   mode      in   1      0 = one-shot, 1 = auto-reload
//   out       out  WIDTH  current count (registered)
//   tc        out  1      terminal-count pulse (registered, one cycle)
//   busy      out  1      high in RUN or HOLD
//   done      out  1      high in DONE
// ---------------------------------------------------------------------------
module universal_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             en,
    input  logic             mode,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] L_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_stateNext;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] w_outNext;
    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] w_reloadNext;
    logic             r_tc;
    logic             w_tcNext;
    logic             w_reloadOk;
    logic             w_outIsOne;
    logic             w_outIsZero;

    // Auto-reload is only meaningful with a non-zero reload value; a zero
    // reload register makes auto-reload mode fall back to one-shot behaviour.
    assign w_reloadOk  = mode && (r_reload != '0);
    assign w_outIsOne  = (r_out == L_ONE);
    assign w_outIsZero = (r_out == '0);

    // State, count, reload and tc registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_out    <= '0;
            r_reload <= '0;
            r_tc     <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_out    <= w_outNext;
            r_reload <= w_reloadNext;
            r_tc     <= w_tcNext;
        end
    end

    // Next-state logic.
    // Each cycle honours at most one command, in the order
    // stop, load, start, pause, en.
    // tc is only raised on the edge where the count steps from 1 to 0,
    // or when starting from an already-zero count.
    // A count that sits at zero in RUN (auto-reload mode) reloads on the
    // next enabled tick without pulsing tc. If auto-reload has been
    // switched off meanwhile, that tick finishes the count instead.
    always_comb begin
        w_stateNext  = r_state;
        w_outNext    = r_out;
        w_reloadNext = r_reload;
        w_tcNext     = 1'b0;
        if (stop) begin
            w_stateNext = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (load) begin
                        w_outNext    = load_val;
                        w_reloadNext = load_val;
                    end else if (start) begin
                        if (!w_outIsZero) begin
                            w_stateNext = RUN;
                        end else begin
                            w_tcNext    = 1'b1;
                            w_stateNext = DONE;
                        end
                    end
                end
                RUN: begin
                    if (pause) begin
                        w_stateNext = HOLD;
                    end else if (en) begin
                        if (w_outIsZero) begin
                            if (w_reloadOk) begin
                                w_outNext = r_reload;
                            end else begin
                                w_stateNext = DONE;
                            end
                        end else begin
                            w_outNext = r_out - L_ONE;
                            if (w_outIsOne) begin
                                w_tcNext = 1'b1;
                                if (!w_reloadOk) begin
                                    w_stateNext = DONE;
                                end
                            end
                        end
                    end
                end
                HOLD: begin
                    if (!pause) begin
                        w_stateNext = RUN;
                    end
                end
                DONE: begin
                    if (load) begin
                        w_outNext    = load_val;
                        w_reloadNext = load_val;
                        w_stateNext  = IDLE;
                    end else if (start) begin
                        w_outNext   = r_reload;
                        w_stateNext = RUN;
                    end
                end
                default: begin
                    w_stateNext = IDLE;
                end
            endcase
        end
    end

    assign out  = r_out;
    assign tc   = r_tc;
    assign busy = (r_state == RUN) || (r_state == HOLD);
    assign done = (r_state == DONE);

endmodule

// File: tb/tb_universal_down_counter.sv
// ---------------------------------------------------------------------------
// tb_universal_down_counter
//
// Self-checking bench for universal_down_counter (WIDTH=4).
// Directed scenario tasks compare against hand-derived constants.
// A randomized run compares every cycle against a behavioural model of the
// counter. The model is kept as plain integers describing what the host
// would expect to see.
// ---------------------------------------------------------------------------
module tb_universal_down_counter;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             stop;
    logic             pause;
    logic             en;
    logic             mode;
    logic [WIDTH-1:0] out;
    logic             tc;
    logic             busy;
    logic             done;

    int nCompared;
    int nMismatched;

    // Behavioural model: phase 0=idle, 1=counting, 2=frozen, 3=finished
    int mPhase;
    int mCount;
    int mReload;
    int mTc;

    universal_down_counter #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .stop     (stop),
        .pause    (pause),
        .en       (en),
        .mode     (mode),
        .out      (out),
        .tc       (tc),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        load     = 1'b0;
        load_val = '0;
        start    = 1'b0;
        stop     = 1'b0;
        pause    = 1'b0;
        en       = 1'b0;
        mode     = 1'b0;
    endtask

    // Model of one clock edge, using the inputs currently applied.
    task automatic modelStep();
        mTc = 0;
        if (stop) begin
            mPhase = 0;
        end else if (mPhase == 0) begin
            if (load) begin
                mCount  = int'(load_val);
                mReload = int'(load_val);
            end else if (start) begin
                if (mCount > 0) begin
                    mPhase = 1;
                end else begin
                    mTc    = 1;
                    mPhase = 3;
                end
            end
        end else if (mPhase == 1) begin
            if (pause) begin
                mPhase = 2;
            end else if (en && mCount > 0) begin
                mCount = mCount - 1;
                if (mCount == 0) begin
                    mTc = 1;
                    if (!(mode && mReload > 0)) mPhase = 3;
                end
            end else if (en) begin
                if (mode && mReload > 0) mCount = mReload;
                else mPhase = 3;
            end
        end else if (mPhase == 2) begin
            if (!pause) mPhase = 1;
        end else begin
            if (load) begin
                mCount  = int'(load_val);
                mReload = int'(load_val);
                mPhase  = 0;
            end else if (start) begin
                mCount = mReload;
                mPhase = 1;
            end
        end
    endtask

    task automatic test_reset();
        logic [WIDTH-1:0] expOut;
        #2;
        nCompared++;
        if ({out, tc, busy, done} !== 7'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset_initial: out=%0d tc=%b busy=%b done=%b, expected all zero", out, tc, busy, done);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        load = 1'b1; load_val = 4'd5;
        applyStimulus();
        load = 1'b0; start = 1'b1;
        applyStimulus();
        start = 1'b0;
        expOut = 4'd5;
        nCompared++;
        if ({out, busy} !== {expOut, 1'b1}) begin
            nMismatched++;
            $display("[TB] FAIL reset_setup_run: out=%0d busy=%b, expected out=5 busy=1", out, busy);
        end
        #2;
        rst = 1'b0;
        #1;
        nCompared++;
        if ({out, tc, busy, done} !== 7'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset_midcount: out=%0d tc=%b busy=%b done=%b, expected all zero", out, tc, busy, done);
        end
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_one_shot();
        logic [WIDTH-1:0] expOut;
        load = 1'b1; load_val = 4'd5;
        applyStimulus();
        load = 1'b0; start = 1'b1; en = 1'b1;
        applyStimulus();
        start = 1'b0;
        nCompared++;
        if ({out, tc, busy, done} !== {4'd5, 1'b0, 1'b1, 1'b0}) begin
            nMismatched++;
            $display("[TB] FAIL one_shot_start: out=%0d tc=%b busy=%b done=%b, expected out=5 tc=0 busy=1 done=0", out, tc, busy, done);
        end
        for (int k = 4; k >= 0; k--) begin
            applyStimulus();
            expOut = WIDTH'(k);
            nCompared++;
            if ({out, tc, busy, done} !== {expOut, k == 0, k != 0, k == 0}) begin
                nMismatched++;
                $display("[TB] FAIL one_shot_step%0d: out=%0d tc=%b busy=%b done=%b, expected out=%0d tc=%b busy=%b done=%b",
                         k, out, tc, busy, done, expOut, k == 0, k != 0, k == 0);
            end
        end
        applyStimulus();
        nCompared++;
        if ({out, tc, busy, done} !== {4'd0, 1'b0, 1'b0, 1'b1}) begin
            nMismatched++;
            $display("[TB] FAIL one_shot_after: out=%0d tc=%b busy=%b done=%b, expected out=0 tc=0 busy=0 done=1", out, tc, busy, done);
        end
        en = 1'b0;
    endtask

    task automatic test_auto_reload();
        int expSeq [8] = '{2, 1, 0, 3, 2, 1, 0, 3};
        logic [WIDTH-1:0] expOut;
        load = 1'b1; load_val = 4'd3;
        applyStimulus();
        nCompared++;
        if ({out, done, busy} !== {4'd3, 1'b0, 1'b0}) begin
            nMismatched++;
            $display("[TB] FAIL auto_load_from_done: out=%0d done=%b busy=%b, expected out=3 done=0 busy=0", out, done, busy);
        end
        load = 1'b0; mode = 1'b1; start = 1'b1; en = 1'b1;
        applyStimulus();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            applyStimulus();
            expOut = WIDTH'(expSeq[k]);
            nCompared++;
            if ({out, tc, busy, done} !== {expOut, expSeq[k] == 0, 1'b1, 1'b0}) begin
                nMismatched++;
                $display("[TB] FAIL auto_step%0d: out=%0d tc=%b busy=%b done=%b, expected out=%0d tc=%b busy=1 done=0",
                         k, out, tc, busy, done, expOut, expSeq[k] == 0);
            end
        end
        stop = 1'b1;
        applyStimulus();
        stop = 1'b0; en = 1'b0; mode = 1'b0;
        nCompared++;
        if ({out, tc, busy, done} !== {4'd3, 1'b0, 1'b0, 1'b0}) begin
            nMismatched++;
            $display("[TB] FAIL auto_stop: out=%0d tc=%b busy=%b done=%b, expected out=3 tc=0 busy=0 done=0", out, tc, busy, done);
        end
    endtask

    task automatic test_pause();
        logic [WIDTH-1:0] expOut;
        load = 1'b1; load_val = 4'd4;
        applyStimulus();
        load = 1'b0; start = 1'b1; en = 1'b1;
        applyStimulus();
        start = 1'b0;
        applyStimulus();
        applyStimulus();
        pause = 1'b1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus();
            nCompared++;
            if ({out, busy, tc} !== {4'd2, 1'b1, 1'b0}) begin
                nMismatched++;
                $display("[TB] FAIL pause_hold%0d: out=%0d busy=%b tc=%b, expected out=2 busy=1 tc=0", k, out, busy, tc);
            end
        end
        pause = 1'b0;
        applyStimulus();
        nCompared++;
        if (out !== 4'd2) begin
            nMismatched++;
            $display("[TB] FAIL pause_resume_edge: out=%0d, expected 2", out);
        end
        applyStimulus();
        applyStimulus();
        nCompared++;
        if ({out, tc, done} !== {4'd0, 1'b1, 1'b1}) begin
            nMismatched++;
            $display("[TB] FAIL pause_finish: out=%0d tc=%b done=%b, expected out=0 tc=1 done=1", out, tc, done);
        end
        load = 1'b1; load_val = 4'd6; en = 1'b0;
        applyStimulus();
        load = 1'b0; start = 1'b1;
        applyStimulus();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            en = (k % 2 == 0);
            applyStimulus();
            expOut = WIDTH'(6 - (k / 2 + 1));
            nCompared++;
            if (out !== expOut) begin
                nMismatched++;
                $display("[TB] FAIL en_gap%0d: out=%0d, expected %0d", k, out, expOut);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_zero_edge();
        logic [WIDTH-1:0] expOut;
        stop = 1'b1;
        applyStimulus();
        stop = 1'b0; load = 1'b1; load_val = 4'd0;
        applyStimulus();
        load = 1'b0; start = 1'b1;
        applyStimulus();
        start = 1'b0;
        nCompared++;
        if ({out, tc, busy, done} !== {4'd0, 1'b1, 1'b0, 1'b1}) begin
            nMismatched++;
            $display("[TB] FAIL zero_start: out=%0d tc=%b busy=%b done=%b, expected out=0 tc=1 busy=0 done=1", out, tc, busy, done);
        end
        applyStimulus();
        nCompared++;
        if ({tc, done} !== 2'b01) begin
            nMismatched++;
            $display("[TB] FAIL zero_tc_single: tc=%b done=%b, expected tc=0 done=1", tc, done);
        end
        load = 1'b1; load_val = 4'd15;
        applyStimulus();
        load = 1'b0; start = 1'b1; en = 1'b1;
        applyStimulus();
        start = 1'b0;
        for (int k = 14; k >= 0; k--) begin
            applyStimulus();
            expOut = WIDTH'(k);
            nCompared++;
            if ({out, tc} !== {expOut, k == 0}) begin
                nMismatched++;
                $display("[TB] FAIL full_range%0d: out=%0d tc=%b, expected out=%0d tc=%b", k, out, tc, expOut, k == 0);
            end
        end
        applyStimulus();
        applyStimulus();
        nCompared++;
        if ({out, tc, done} !== {4'd0, 1'b0, 1'b1}) begin
            nMismatched++;
            $display("[TB] FAIL no_wrap: out=%0d tc=%b done=%b, expected out=0 tc=0 done=1", out, tc, done);
        end
        en = 1'b0;
    endtask

    task automatic test_priority();
        load = 1'b1; load_val = 4'd9;
        applyStimulus();
        load = 1'b0; start = 1'b1; en = 1'b1;
        applyStimulus();
        start = 1'b0;
        applyStimulus();
        load = 1'b1; load_val = 4'd2; en = 1'b0;
        applyStimulus();
        nCompared++;
        if ({out, busy} !== {4'd8, 1'b1}) begin
            nMismatched++;
            $display("[TB] FAIL load_in_run_ignored: out=%0d busy=%b, expected out=8 busy=1", out, busy);
        end
        stop = 1'b1;
        applyStimulus();
        stop = 1'b0; load = 1'b0;
        nCompared++;
        if ({out, tc, busy, done} !== {4'd8, 1'b0, 1'b0, 1'b0}) begin
            nMismatched++;
            $display("[TB] FAIL stop_beats_load: out=%0d tc=%b busy=%b done=%b, expected out=8 tc=0 busy=0 done=0", out, tc, busy, done);
        end
        load = 1'b1; load_val = 4'd1;
        applyStimulus();
        load = 1'b0; start = 1'b1; en = 1'b1;
        applyStimulus();
        start = 1'b0;
        applyStimulus();
        en = 1'b0;
        start = 1'b1; load = 1'b1; load_val = 4'd7;
        applyStimulus();
        load = 1'b0;
        nCompared++;
        if ({out, busy, done} !== {4'd7, 1'b0, 1'b0}) begin
            nMismatched++;
            $display("[TB] FAIL done_load_beats_start: out=%0d busy=%b done=%b, expected out=7 busy=0 done=0", out, busy, done);
        end
        applyStimulus();
        start = 1'b0;
        en = 1'b1;
        repeat (7) applyStimulus();
        en = 1'b0;
        start = 1'b1;
        applyStimulus();
        start = 1'b0;
        nCompared++;
        if ({out, busy, done} !== {4'd7, 1'b1, 1'b0}) begin
            nMismatched++;
            $display("[TB] FAIL done_restart_reload: out=%0d busy=%b done=%b, expected out=7 busy=1 done=0", out, busy, done);
        end
    endtask

    task automatic test_random();
        clearInputs();
        rst = 1'b0;
        #1;
        mPhase = 0; mCount = 0; mReload = 0; mTc = 0;
        applyStimulus();
        rst = 1'b1;
        for (int k = 0; k < 600; k++) begin
            stop     = ($urandom_range(0, 31) == 0);
            load     = ($urandom_range(0, 9) == 0);
            load_val = WIDTH'($urandom_range(0, 15));
            start    = ($urandom_range(0, 5) == 0);
            pause    = ($urandom_range(0, 7) == 0);
            en       = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            modelStep();
            applyStimulus();
            nCompared++;
            if ({out, tc, busy, done} !== {WIDTH'(mCount), mTc == 1, mPhase == 1 || mPhase == 2, mPhase == 3}) begin
                nMismatched++;
                $display("[TB] FAIL random_cycle%0d: out=%0d tc=%b busy=%b done=%b, expected out=%0d tc=%0d busy=%b done=%b",
                         k, out, tc, busy, done, mCount, mTc, mPhase == 1 || mPhase == 2, mPhase == 3);
            end
        end
        clearInputs();
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        clk = 1'b0;
        rst = 1'b0;
        clearInputs();
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_pause();
        test_zero_edge();
        test_priority();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
